// File: rtl/adder_st_pkg.sv
// Shared types and constants for the adder self-test driver.
// Optional feature macro used by the driver: ADDER_ST_STOP_ON_FAIL_EN.
package adder_st_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } st_state_e;

  localparam int ST_W    = 3;
  localparam int VEC_W   = 2 * ST_W + 1;
  localparam int N_VEC   = 2 ** VEC_W;
  localparam int A_LSB   = 0;
  localparam int B_LSB   = ST_W;
  localparam int CIN_BIT = 2 * ST_W;

  localparam logic [7:0] ERR_SAT = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == ERR_SAT) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_st_ref_model.sv
// Combinational reference: {Cin,B,A} -> full-width expected sum (W+1 bits).
module adder_st_ref_model #(
  parameter int W = 3
) (
  input  logic [2*W:0] i_vec,
  output logic [W:0]   o_sum
);

  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic         w_cin;

  assign w_a   = i_vec[0 +: W];
  assign w_b   = i_vec[W +: W];
  assign w_cin = i_vec[2*W];

  // Zero-extend every term so the carry out is kept.
  assign o_sum = {1'b0, w_a} + {1'b0, w_b} + {{W{1'b0}}, w_cin};

endmodule

// File: rtl/adder_selftest_driver.sv
// Sweeps every {Cin,B,A} vector through an external adder and checks the sums.
// Build option: ADDER_ST_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module adder_selftest_driver
  import adder_st_pkg::*;
#(
  parameter int W             = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           start,
  output logic [7:0]     dut_ui,
  input  logic [7:0]     dut_uo,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [7:0]     err_count,
  output logic [2*W:0]   fail_vec,
  output logic [W:0]     fail_got
);

  localparam int VW = 2 * W + 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [VW-1:0] LAST_VEC = {VW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  if ((2 * W + 1) > 8 || (W + 1) > 8 || SETTLE_CYCLES < 1) begin : g_bad_params
    $error("adder_selftest_driver: illegal W/SETTLE_CYCLES");
  end

  st_state_e     r_state;
  st_state_e     w_state_nxt;
  logic [VW-1:0] r_vec,      w_vec_nxt;
  logic [CW-1:0] r_cnt,      w_cnt_nxt;
  logic [7:0]    r_dut_ui,   w_ui_nxt;
  logic          r_busy,     w_busy_nxt;
  logic          r_done,     w_done_nxt;
  logic          r_pass,     w_pass_nxt;
  logic [7:0]    r_err,      w_err_nxt;
  logic [VW-1:0] r_fail_vec, w_fvec_nxt;
  logic [W:0]    r_fail_got, w_fgot_nxt;

  logic [W:0]    w_exp;
  logic [W:0]    w_got;
  logic          w_mismatch;
  logic          w_last;
  logic          w_unused_uo;

  adder_st_ref_model #(.W(W)) u_ref (
    .i_vec (r_vec),
    .o_sum (w_exp)
  );

  assign w_got       = dut_uo[W:0];
  assign w_unused_uo = ^dut_uo[7:W+1];
  assign w_mismatch  = (w_got != w_exp);

`ifdef ADDER_ST_STOP_ON_FAIL_EN
  assign w_last = (r_vec == LAST_VEC) || w_mismatch;
`else
  assign w_last = (r_vec == LAST_VEC);
`endif

  // Next-state and next-register values; everything holds while ena is low.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_ui_nxt    = r_dut_ui;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_fvec_nxt  = r_fail_vec;
    w_fgot_nxt  = r_fail_got;
    if (ena) begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_state_nxt = ST_DRIVE;
            w_vec_nxt   = {VW{1'b0}};
            w_busy_nxt  = 1'b1;
            w_done_nxt  = 1'b0;
            w_pass_nxt  = 1'b0;
            w_err_nxt   = 8'd0;
            w_fvec_nxt  = {VW{1'b0}};
            w_fgot_nxt  = {(W+1){1'b0}};
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_DRIVE: begin
          w_ui_nxt    = 8'(r_vec);
          w_cnt_nxt   = {CW{1'b0}};
          w_state_nxt = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_CHECK;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            w_err_nxt = sat_inc(r_err);
            // err_count is cleared on start, so zero here means first failure.
            if (r_err == 8'd0) begin
              w_fvec_nxt = r_vec;
              w_fgot_nxt = w_got;
            end else begin
              w_fvec_nxt = r_fail_vec;
            end
          end else begin
            w_err_nxt = r_err;
          end
          if (w_last) begin
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_err_nxt == 8'd0);
          end else begin
            w_vec_nxt   = r_vec + VW'(1);
            w_state_nxt = ST_DRIVE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Vector, settle counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec      <= {VW{1'b0}};
      r_cnt      <= {CW{1'b0}};
      r_dut_ui   <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= 8'd0;
      r_fail_vec <= {VW{1'b0}};
      r_fail_got <= {(W+1){1'b0}};
    end else begin
      r_vec      <= w_vec_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dut_ui   <= w_ui_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_err      <= w_err_nxt;
      r_fail_vec <= w_fvec_nxt;
      r_fail_got <= w_fgot_nxt;
    end
  end

  assign dut_ui    = r_dut_ui;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail_vec;
  assign fail_got  = r_fail_got;

endmodule

// File: tb/tb_adder_selftest_driver.sv
// Bench for adder_selftest_driver: emulated (optionally faulty) adder plus sweep model.
module tb_adder_selftest_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       start;
  logic [7:0] dut_ui;
  logic [7:0] dut_uo;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [6:0] fail_vec;
  logic [3:0] fail_got;

  int n_assert = 0;
  int n_fail   = 0;
  int fault_mode = 0;
  logic [3:0] corrupt [128];

  adder_selftest_driver #(.W(3), .SETTLE_CYCLES(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .start     (start),
    .dut_ui    (dut_ui),
    .dut_uo    (dut_uo),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec),
    .fail_got  (fail_got)
  );

  always #5 clk = ~clk;

  // Adder under test: 0 golden, 1 Cout stuck-at-0, 2 Sum inverted, 3 table corruption.
  function automatic logic [3:0] fake_adder(input logic [6:0] v);
    logic [3:0] s;
    s = {1'b0, v[2:0]} + {1'b0, v[5:3]} + {3'b000, v[6]};
    case (fault_mode)
      1: s[3] = 1'b0;
      2: s[2:0] = ~s[2:0];
      3: s = s ^ corrupt[v];
      default: s = s;
    endcase
    return s;
  endfunction

  always_comb dut_uo = {4'b1010, fake_adder(dut_ui[6:0])};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-sweep expectation from plain arithmetic over all 128 vectors.
  task automatic model(output int e_err, output int e_fvec, output int e_fgot,
                       output int e_cyc, output int e_last);
    int a, b, c, s, got;
    e_err = 0; e_fvec = 0; e_fgot = 0; e_cyc = 128 * 4; e_last = 127;
    for (int v = 0; v < 128; v++) begin
      a = v % 8;
      b = (v / 8) % 8;
      c = v / 64;
      s = a + b + c;
      got = int'(fake_adder(7'(v)));
      if (got != s) begin
        if (e_err == 0) begin
          e_fvec = v;
          e_fgot = got;
        end
        e_err++;
`ifdef ADDER_ST_STOP_ON_FAIL_EN
        e_cyc  = (v + 1) * 4;
        e_last = v;
        break;
`endif
      end
    end
  endtask

  task automatic run_sweep(input string tag, input int gap_at, input int gap_len,
                           input int repulse_at);
    int e_err, e_fvec, e_fgot, e_cyc, e_last, k;
    model(e_err, e_fvec, e_fgot, e_cyc, e_last);
    e_cyc = e_cyc + gap_len;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_done_clr"}, done, 0);
    k = 0;
    while (done !== 1'b1 && k < 3000) begin
      if (k == gap_at) ena = 1'b0;
      if (k == gap_at + gap_len) ena = 1'b1;
      start = (k == repulse_at);
      @(negedge clk);
      k++;
    end
    ena = 1'b1; start = 1'b0;
    check({tag, "_cycles"}, k, e_cyc);
    check({tag, "_err"}, err_count, e_err);
    check({tag, "_pass"}, pass, (e_err == 0) ? 1 : 0);
    check({tag, "_fvec"}, fail_vec, e_fvec);
    check({tag, "_fgot"}, fail_got, e_fgot);
    check({tag, "_busy_end"}, busy, 0);
    repeat (5) @(negedge clk);
    check({tag, "_done_held"}, done, 1);
    check({tag, "_ui_held"}, dut_ui, e_last);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_fvec"}, fail_vec, 0);
    check({tag, "_fgot"}, fail_got, 0);
    check({tag, "_ui"}, dut_ui, 0);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; start = 1'b0;
    for (int i = 0; i < 128; i++) corrupt[i] = 4'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    fault_mode = 0; run_sweep("golden", -1, 0, -1);
    fault_mode = 1; run_sweep("cout0", -1, 0, -1);
    fault_mode = 2; run_sweep("suminv", -1, 0, -1);

    fault_mode = 3;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 128; i++)
        corrupt[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      run_sweep("random", -1, 0, -1);
    end

    // Reset in the middle of a sweep, then a fresh full sweep.
    fault_mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("midrst");
    @(negedge clk); rst = 1'b0;
    run_sweep("after_rst", -1, 0, -1);

    run_sweep("ena_gap", 300, 10, 100);
    run_sweep("ena_rand", $urandom_range(20, 400), $urandom_range(1, 20),
              $urandom_range(5, 15));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
